// File: rtl/conv_tile_loader_pkg.sv
// Shared definitions for the conv tile loader: default geometry and FSM encoding.
package conv_tile_loader_pkg;

  localparam int unsigned DefDataW     = 16;
  localparam int unsigned DefIfmapN    = 25;
  localparam int unsigned DefFilterN   = 9;
  localparam int unsigned DefRunCycles = 6;
  localparam int unsigned WordCntW     = 6;

  typedef enum logic [2:0] {
    StLdIf = 3'd0,
    StLdFl = 3'd1,
    StArm  = 3'd2,
    StRun  = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic int unsigned tile_words(input int unsigned ifmap_n,
                                             input int unsigned filter_n);
    return ifmap_n + filter_n;
  endfunction

endpackage

// File: rtl/conv_tile_loader.sv
// Streams a 5x5 ifmap tile and a 3x3 filter into flat buses, then sequences the
// PE array through load, run and done.
module conv_tile_loader
  import conv_tile_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned IFMAP_N    = DefIfmapN,
  parameter int unsigned FILTER_N   = DefFilterN,
  parameter int unsigned RUN_CYCLES = DefRunCycles
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  input  logic                         err_clr,
  output logic [IFMAP_N*DATA_W-1:0]    ifmap_in_flat,
  output logic [FILTER_N*DATA_W-1:0]   filter_in_flat,
  output logic                         arr_load,
  output logic                         arr_en,
  output logic                         busy,
  output logic                         tile_done,
  output logic                         err
);

  localparam int unsigned TileWords = tile_words(IFMAP_N, FILTER_N);
  localparam int unsigned RunCntW   = $clog2(RUN_CYCLES + 1);

  state_e              state_q, state_d;
  logic [WordCntW-1:0] wcnt_q, wcnt_d;
  logic [RunCntW-1:0]  rcnt_q, rcnt_d;
  logic                err_q, err_set;
  logic                accept, last_word;

  assign s_ready   = (state_q == StLdIf) || (state_q == StLdFl);
  assign accept    = s_valid && s_ready;
  assign last_word = (wcnt_q == WordCntW'(TileWords - 1));

  assign arr_load  = (state_q == StArm);
  assign arr_en    = (state_q == StRun);
  assign tile_done = (state_q == StDone);
  assign busy      = !((state_q == StLdIf) && (wcnt_q == '0));
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    err_set = 1'b0;
    unique case (state_q)
      StLdIf: begin
        if (accept) begin
          // Any s_last during the ifmap phase is early: drop the tile.
          if (s_last) begin
            err_set = 1'b1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WordCntW'(IFMAP_N - 1)) state_d = StLdFl;
          end
        end
      end
      StLdFl: begin
        if (accept) begin
          if (last_word) begin
            // A missing s_last is flagged but the tile still runs.
            err_set = !s_last;
            wcnt_d  = '0;
            state_d = StArm;
          end else if (s_last) begin
            err_set = 1'b1;
            wcnt_d  = '0;
            state_d = StLdIf;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StArm: begin
        rcnt_d  = '0;
        state_d = StRun;
      end
      StRun: begin
        if (rcnt_q == RunCntW'(RUN_CYCLES - 1)) begin
          rcnt_d  = '0;
          state_d = StDone;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StDone: begin
        wcnt_d  = '0;
        state_d = StLdIf;
      end
      default: state_d = StLdIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StLdIf;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      err_q          <= 1'b0;
      ifmap_in_flat  <= '0;
      filter_in_flat <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_set || (err_q && !err_clr);
      for (int k = 0; k < IFMAP_N; k++) begin
        if (accept && (state_q == StLdIf) && (wcnt_q == WordCntW'(k))) begin
          ifmap_in_flat[k*DATA_W +: DATA_W] <= s_data;
        end
      end
      for (int k = 0; k < FILTER_N; k++) begin
        if (accept && (state_q == StLdFl) && (wcnt_q == WordCntW'(IFMAP_N + k))) begin
          filter_in_flat[k*DATA_W +: DATA_W] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_loader.sv
// Self-checking bench for conv_tile_loader against a word-list reference model.
module tb_conv_tile_loader;

  localparam int DW = 16;
  localparam int IN = 25;
  localparam int FN = 9;
  localparam int TW = IN + FN;
  localparam int RC = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_data = '0;
  logic             s_last = 1'b0;
  logic             err_clr = 1'b0;
  logic [IN*DW-1:0] ifmap_in_flat;
  logic [FN*DW-1:0] filter_in_flat;
  logic             arr_load, arr_en, busy, tile_done, err;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;

  // Reference model: slot images, position within the tile and the sticky error.
  logic [DW-1:0] exp_if [IN];
  logic [DW-1:0] exp_fl [FN];
  int            m_pos;
  bit            m_err;
  bit            m_armed;

  conv_tile_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .err_clr        (err_clr),
    .ifmap_in_flat  (ifmap_in_flat),
    .filter_in_flat (filter_in_flat),
    .arr_load       (arr_load),
    .arr_en         (arr_en),
    .busy           (busy),
    .tile_done      (tile_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (s_valid && s_ready && !rst) acc_cnt++;

  task automatic model_reset();
    for (int k = 0; k < IN; k++) exp_if[k] = '0;
    for (int k = 0; k < FN; k++) exp_fl[k] = '0;
    m_pos = 0;
    m_err = 1'b0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit last, input bit clr);
    bit set;
    set = 1'b0;
    m_armed = 1'b0;
    if (m_pos < IN) exp_if[m_pos] = d;
    else exp_fl[m_pos-IN] = d;
    if (m_pos == TW - 1) begin
      set = !last;
      m_armed = 1'b1;
      m_pos = 0;
    end else if (last) begin
      set = 1'b1;
      m_pos = 0;
    end else begin
      m_pos++;
    end
    m_err = set || (m_err && !clr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) for it to be taken.
  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit clr);
    bit taken;
    taken = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    err_clr = clr;
    for (int w = 0; w < 20 && !taken; w++) begin
      taken = s_ready;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    err_clr = 1'b0;
    total++;
    if (!taken) begin
      bad++;
      $display("FAIL beat_accept: s_ready never seen high, required 1");
    end else begin
      model_beat(d, last, clr);
    end
  endtask

  // gap: 0 back-to-back, 1 alternate idle cycle, 2 random idle cycles.
  task automatic stream(input int n, input int last_idx, input int gap, input bit rnd,
                        input int base, input bit clr_on_last);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (gap == 1 && i > 0) step();
      if (gap == 2) repeat ($urandom_range(0, 2)) step();
      d = rnd ? DW'($urandom) : DW'(base + i);
      send_beat(d, i == last_idx, clr_on_last && (i == last_idx));
    end
  endtask

  task automatic check_bufs(input string name);
    logic [IN*DW-1:0] ei;
    logic [FN*DW-1:0] ef;
    for (int k = 0; k < IN; k++) ei[k*DW +: DW] = exp_if[k];
    for (int k = 0; k < FN; k++) ef[k*DW +: DW] = exp_fl[k];
    total++;
    if (ifmap_in_flat !== ei) begin
      bad++;
      $display("FAIL %s_ifmap: got %h required %h", name, ifmap_in_flat, ei);
    end
    total++;
    if (filter_in_flat !== ef) begin
      bad++;
      $display("FAIL %s_filter: got %h required %h", name, filter_in_flat, ef);
    end
    total++;
    if (err !== m_err) begin
      bad++;
      $display("FAIL %s_err: got %b required %b", name, err, m_err);
    end
  endtask

  // Called right after the final accept edge (cycle T+1); walks to T+1+RC+2.
  task automatic check_tail(input string name, input bit armed);
    logic [3:0] got, exp;
    for (int i = 1; i <= RC + 3; i++) begin
      if (armed)
        exp = {i == 1, (i >= 2) && (i <= RC + 1), i == RC + 2, i >= RC + 3};
      else
        exp = 4'b0001;
      got = {arr_load, arr_en, tile_done, s_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s_tail_T+%0d: {load,en,done,ready} got %b required %b",
                 name, i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    total++;
    if ({arr_load, arr_en, tile_done, err, busy, s_ready} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_ctrl: {load,en,done,err,busy,ready} got %b required 000001",
               {arr_load, arr_en, tile_done, err, busy, s_ready});
    end
    check_bufs("reset");
  endtask

  task automatic test_stream();
    stream(TW, TW - 1, 0, 1'b0, 1, 1'b0);
    total++;
    if (ifmap_in_flat[15:0] !== 16'd1 || ifmap_in_flat[399:384] !== 16'd25 ||
        filter_in_flat[15:0] !== 16'd26 || filter_in_flat[143:128] !== 16'd34) begin
      bad++;
      $display("FAIL stream_corners: got %0d %0d %0d %0d required 1 25 26 34",
               ifmap_in_flat[15:0], ifmap_in_flat[399:384], filter_in_flat[15:0],
               filter_in_flat[143:128]);
    end
    check_bufs("stream");
    check_tail("stream", m_armed);
  endtask

  task automatic test_gapped();
    int a0;
    a0 = acc_cnt;
    stream(TW, TW - 1, 1, 1'b0, 1, 1'b0);
    check_bufs("gapped");
    check_tail("gapped", m_armed);
    total++;
    if (acc_cnt - a0 !== TW) begin
      bad++;
      $display("FAIL gapped_accepts: got %0d required %0d", acc_cnt - a0, TW);
    end
  endtask

  task automatic test_early_last();
    stream(10, 9, 0, 1'b0, 500, 1'b0);
    check_bufs("early_last");
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL early_last_busy: got %b required 0", busy);
    end
    check_tail("early_last", 1'b0);
    stream(TW, TW - 1, 0, 1'b0, 101, 1'b0);
    total++;
    if (ifmap_in_flat[15:0] !== 16'd101) begin
      bad++;
      $display("FAIL early_last_retry: ifmap0 got %0d required 101", ifmap_in_flat[15:0]);
    end
    check_bufs("early_last_retry");
    check_tail("early_last_retry", m_armed);
  endtask

  task automatic test_missing_last();
    stream(TW, -1, 0, 1'b0, 200, 1'b0);
    check_bufs("missing_last");
    check_tail("missing_last", m_armed);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b required 0", err);
    end
  endtask

  task automatic test_rst_mid_run();
    stream(TW, TW - 1, 2, 1'b1, 0, 1'b0);
    step();
    step();
    step();
    total++;
    if (arr_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_run_en: got %b required 1", arr_en);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    total++;
    if ({arr_en, err, s_ready, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL rst_mid_run: {en,err,ready,busy} got %b required 0010",
               {arr_en, err, s_ready, busy});
    end
    check_bufs("rst_mid_run");
  endtask

  task automatic test_err_collision();
    stream(5, 4, 0, 1'b0, 300, 1'b1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set_wins: got %b required 1", err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_random_tiles();
    for (int t = 0; t < 4; t++) begin
      stream(TW, TW - 1, 2, 1'b1, 0, 1'b0);
      check_bufs("random");
      check_tail("random", m_armed);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gapped();
    test_early_last();
    test_missing_last();
    test_err_collision();
    test_random_tiles();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
